// File: rtl/fabm_final_add_seq_if.sv
`default_nettype none
// ============================================================================
// fabm_final_add_seq_if : operand/result handshake bundle for the sequential
// FABM final adder.   Rev 1.0
// ============================================================================
interface fabm_final_add_seq_if #(
  parameter int LSB = 17,
  parameter int MSB = 55
);
  localparam int PW = MSB - LSB + 1;
  localparam int W  = MSB - LSB + 2;

  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] prop;
  logic [PW-1:0] gen;
  logic          cin;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  product;
  logic          busy;

  modport master (
    output in_valid, prop, gen, cin, abort, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, prop, gen, cin, abort, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface
`default_nettype wire

// File: rtl/fabm_final_add_seq.sv
`default_nettype none
// ============================================================================
// fabm_final_add_seq : time-shared SEG_W-column carry chain resolving the FABM
// final prop/gen columns one segment per cycle.   Rev 1.0
// ============================================================================
module fabm_final_add_seq #(
  parameter int LSB   = 17,
  parameter int MSB   = 55,
  parameter int SEG_W = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  fabm_final_add_seq_if.slave    bus
);
  localparam int PW    = MSB - LSB + 1;
  localparam int W     = MSB - LSB + 2;
  localparam int NSEG  = (W + SEG_W - 1) / SEG_W;
  localparam int PADW  = NSEG * SEG_W;
  localparam int SEGCW = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [PADW-1:0]   r_prop;
  logic [PADW-1:0]   r_gen;
  logic [PADW-1:0]   r_res;
  logic              r_carry;
  logic [SEGCW-1:0]  r_seg;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic [SEG_W-1:0]  w_sum;
  logic              w_c;

  // Operands shift right each cycle so the active segment always sits in the
  // low SEG_W bits; the result fills from the top and lands aligned after NSEG.
  always_comb begin
    w_sum = '0;
    w_c   = r_carry;
    for (int i = 0; i < SEG_W; i++) begin
      w_sum[i] = r_prop[i] ^ w_c;
      w_c      = r_prop[i] ? w_c : r_gen[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_prop      <= '0;
      r_gen       <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_seg       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && !bus.abort) begin
            r_prop     <= PADW'(bus.prop);
            r_gen      <= PADW'(bus.gen);
            r_carry    <= bus.cin;
            r_seg      <= '0;
            r_res      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_prop  <= r_prop >> SEG_W;
            r_gen   <= r_gen >> SEG_W;
            r_res   <= PADW'({w_sum, r_res} >> SEG_W);
            r_carry <= w_c;
            if (r_seg == SEGCW'(NSEG - 1)) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_seg <= r_seg + SEGCW'(1);
            end
          end
        end
        S_DONE: begin
          if (bus.abort || bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.product   = r_res[W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fabm_final_add_seq.sv
`default_nettype none
// ============================================================================
// tb_fabm_final_add_seq : scoreboard bench for the sequential final adder,
// reference is plain two-operand addition.   Rev 1.0
// ============================================================================
module tb_fabm_final_add_seq;
  localparam int LSB  = 17;
  localparam int MSB  = 55;
  localparam int PW   = MSB - LSB + 1;
  localparam int W    = MSB - LSB + 2;
  localparam int NSEG = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fabm_final_add_seq_if #(.LSB(LSB), .MSB(MSB)) bus ();

  fabm_final_add_seq #(.LSB(LSB), .MSB(MSB), .SEG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  int last_acc = 0;
  bit have_last = 0;
  bit rand_stall = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // A prop/gen column pair is exactly the column of a + b with a=gen, b=gen^prop.
  function automatic logic [W-1:0] ref_model(input logic [PW-1:0] p, input logic [PW-1:0] g,
                                             input logic c);
    return {1'b0, g} + {1'b0, g ^ p} + W'(c);
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready) begin
      n++;
      if (n > 500) begin
        chk("in_ready_timeout", 64'd0, 64'd1);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [PW-1:0] p, input logic [PW-1:0] g, input logic c,
                      input logic [W-1:0] expv);
    wait_ready();
    bus.prop = p;
    bus.gen = g;
    bus.cin = c;
    bus.in_valid = 1'b1;
    exp_q.push_back(expv);
    acc_cyc = cyc + 1;
    if (have_last) chk("init_interval_ge_12", 64'(acc_cyc - last_acc >= NSEG + 2), 64'd1);
    last_acc = acc_cyc;
    have_last = 1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic start_unscored(input logic [PW-1:0] p);
    wait_ready();
    bus.prop = p;
    bus.gen = '0;
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0) begin
      n++;
      if (n > 2000) begin
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        return;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_product"}, 64'(bus.product), 64'd0);
  endtask

  // Monitor: checks every presented result against the scoreboard.
  logic prev_valid = 1'b0;
  logic [W-1:0] prev_prod = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.busy) chk("in_ready_low_while_busy", 64'(bus.in_ready), 64'd0);
        if (bus.out_valid && !prev_valid) chk("latency", 64'(cyc - acc_cyc), 64'(NSEG));
        if (bus.out_valid && prev_valid) chk("product_stable_done", 64'(bus.product), 64'(prev_prod));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got %0h expected none", bus.product);
          end else begin
            chk("product", 64'(bus.product), 64'(exp_q.pop_front()));
          end
        end
        prev_valid = bus.out_valid;
      end else begin
        prev_valid = 1'b0;
      end
      prev_prod = bus.product;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_stall) bus.out_ready = ($urandom_range(3) != 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p, g;
    logic c;
    bus.in_valid = 1'b0;
    bus.prop = '0;
    bus.gen = '0;
    bus.cin = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;

    send({PW{1'b1}}, '0, 1'b1, 40'h80_0000_0000);
    send('0, {PW{1'b1}}, 1'b0, 40'hFF_FFFF_FFFE);
    send('0, {PW{1'b1}}, 1'b1, 40'hFF_FFFF_FFFF);
    drain();

    rand_stall = 1;
    for (int k = 0; k < 1000; k++) begin
      p = PW'({$urandom(), $urandom()});
      g = PW'({$urandom(), $urandom()});
      c = 1'($urandom_range(1));
      send(p, g, c, ref_model(p, g, c));
    end
    drain();
    rand_stall = 0;

    // Backpressure with a stray in_valid pulse during the stall.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(39'h5, '0, 1'b0, 40'h5);
    begin
      int n = 0;
      while (!bus.out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("stall_product", 64'(bus.product), 64'h5);
      bus.in_valid = (i == 5);
      bus.prop = 39'h7;
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    chk("stray_in_valid_not_captured", 64'(bus.busy), 64'd0);

    // Abort at seg=3.
    start_unscored(39'h1234);
    repeat (3) @(posedge clk);
    @(negedge clk) bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    repeat (20) @(negedge clk);
    bus.abort = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_blocks_accept", 64'(bus.busy), 64'd0);
    send(39'h1, '0, 1'b1, 40'h2);
    drain();

    // Asynchronous reset mid-RUN.
    start_unscored(39'h7FFF);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk) rst_n = 1'b1;
    p = PW'({$urandom(), $urandom()});
    g = PW'({$urandom(), $urandom()});
    send(p, g, 1'b1, ref_model(p, g, 1'b1));
    drain();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fabm_final_add_seq.md
Name: fabm_final_add_seq

Overview:
- Sequential, area-reduced alternative to the full-width final carry-propagate adder of the 32x32 FABM signed approximate multiplier.
- Accepts one propagate/generate pair per operation, covering product columns [MSB:LSB] plus a carry-in.
- Time-shares a single SEG_W-bit carry-chain segment across the column range, one segment per cycle, with the inter-segment carry held in a register.
- Delivers the assembled product columns [MSB+1:LSB] on a valid/ready output handshake.
- Sits between the partial-product compression stage and the product register.

Parameters:
- LSB, 17, lowest product column handled.
- MSB, 55, highest prop/gen column.
  - W = MSB-LSB+2 = 40, the result width.
- SEG_W, 4, columns resolved per cycle.
  - NSEG = ceil(W/SEG_W) = 10.
  - Internal operand registers are zero-padded to NSEG*SEG_W bits.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, operand valid.
- in_ready, out, 1, block can accept an operand.
- prop, in, MSB-LSB+1, propagate bits for columns [MSB:LSB].
- gen, in, MSB-LSB+1, generate bits (carry-mux data) for columns [MSB:LSB].
- cin, in, 1, carry into column LSB.
- abort, in, 1, synchronous cancel of the current operation.
- out_valid, out, 1, product valid.
- out_ready, in, 1, consumer accepts product.
- product, out, W, result columns [MSB+1:LSB]; bit 0 corresponds to column LSB.
- busy, out, 1, high in RUN or DONE.

Behaviour:
- Per-column arithmetic (carry-chain semantics), for column i:
  - sum_i = prop_i XOR c_i
  - c_{i+1} = prop_i ? c_i : gen_i
  - Column MSB+1 and all padding columns use prop=0, gen=0, so product[W-1] = carry out of column MSB.
  - Carry out of the top padding segment is discarded.
- Reset (async, rst_n=0):
  - State=IDLE; in_ready=1; out_valid=0; busy=0; product=0.
  - Carry, segment counter and operand registers are cleared.
  - Reset mid-operation drops the operation silently.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch zero-padded prop/gen, carry<=cin, seg<=0, result register<=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each edge resolves segment seg: columns [seg*SEG_W +: SEG_W] are written to the result register, and the carry register takes the segment carry-out.
  - On seg==NSEG-1, go to DONE; otherwise seg<=seg+1.
- DONE:
  - out_valid=1.
  - product holds the full result, stable until the handshake.
  - On an edge with out_ready=1, go to IDLE. The new operand is accepted no earlier than the following edge; there is no same-cycle re-accept.
- Latency:
  - An operand accepted at edge k gives out_valid=1 in the cycle after edge k+NSEG (10 RUN edges).
  - Minimum initiation interval is NSEG+2 = 12 cycles.
- product is updated only from the result register. It is not required to be meaningful while out_valid=0, but it must be held constant in DONE.
- abort:
  - In RUN or DONE, the next edge goes to IDLE with out_valid=0. No output handshake occurs.
  - abort has priority over out_ready and over RUN progress.
  - abort in IDLE has priority over in_valid: no accept occurs that edge.
- in_valid while not in IDLE is ignored; the operand is not captured.
- If out_ready is held low, DONE persists indefinitely with no timeout.

Test Plan:
- Carry ripple across all segments: prop=all ones, gen=0, cin=1 -> product=40'h80_0000_0000, out_valid rises 10 cycles after accept.
- Generate path: prop=0, gen=all ones, cin=0 -> product=40'hFF_FFFF_FFFE. Same operands with cin=1 -> 40'hFF_FFFF_FFFF.
- Random operands: 1000 random prop/gen/cin with random out_ready stalls -> product equals the bitwise reference model of the column equations; in_ready=0 throughout RUN/DONE; back-to-back interval >= 12 cycles.
- Backpressure: prop=39'h5, gen=0, cin=0, out_ready=0 for 15 cycles after out_valid -> product stays 40'h5, and an in_valid pulse during the stall is not captured.
- Abort: assert abort during RUN at seg=3 -> IDLE next edge, out_valid never asserts. A following operand prop=39'h1, cin=1 -> product=40'h2.
- Reset: deassert rst_n asynchronously mid-RUN -> outputs immediately at reset values (in_ready=1, out_valid=0, busy=0, product=0). After release, a new operation completes correctly.
